// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: byte FIFO in front of the transmitter, sequencing one frame
// at a time with CTS gating, a START timeout/retry, flush, overflow and empty-interrupt.
module uart_tx_ctrl #(
    parameter int FIFO_DEPTH    = 16,
    parameter int START_TIMEOUT = 1023,
    parameter int LVL_W         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [7:0]       wr_data_i,
    input  logic             flush_i,
    input  logic             tx_en_i,
    input  logic             ovf_clr_i,
    input  logic             cts_n,
    input  logic             tx_done_i,
    output logic             start_tx_o,
    output logic [31:0]      tx_data_o,
    output logic             fifo_full_o,
    output logic             fifo_empty_o,
    output logic [LVL_W-1:0] fifo_level_o,
    output logic             tx_busy_o,
    output logic             overflow_o,
    output logic             tx_irq_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, START, WAIT_DONE} state_t;

    state_t        state_q, state_d;
    logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [7:0]    data_q, data_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic             full, empty, pop, wr_acc, ovf_set;
    logic [LVL_W-1:0] level;

    always_comb begin
        full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        empty   = (wptr_q == rptr_q);
        level   = LVL_W'(wptr_q - rptr_q);
        // A flushed frame still finishes on the wire but must not pop an emptied FIFO.
        pop     = (state_q == WAIT_DONE) && tx_done_i && !flush_i && !empty;
        wr_acc  = wr_en_i && !flush_i && (!full || pop);
        ovf_set = wr_en_i && !flush_i && full && !pop;
        ovf_d   = ovf_set || (ovf_q && !ovf_clr_i);
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            wptr_d = wptr_q + {{AW{1'b0}}, wr_acc};
            rptr_d = rptr_q + {{AW{1'b0}}, pop};
        end
        cnt_inc = cnt_q + CW'(1);
        cnt_d   = (state_q == START) ? cnt_inc : '0;
        data_d  = (state_q == LOAD) ? mem_q[rptr_q[AW-1:0]] : data_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (tx_en_i && !empty && !cts_n && !flush_i) state_d = LOAD;
            LOAD:      state_d = flush_i ? IDLE : START;
            START: begin
                if (flush_i)                          state_d = IDLE;
                else if (!tx_done_i)                  state_d = WAIT_DONE;
                else if (cnt_inc == CW'(START_TIMEOUT)) state_d = IDLE;
            end
            WAIT_DONE: if (tx_done_i) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        start_tx_o = (state_q == START);
        tx_busy_o  = (state_q != IDLE);
        tx_irq_o   = (state_q == WAIT_DONE) && tx_done_i && !flush_i &&
                     (level == LVL_W'(1)) && !wr_en_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
    end

    assign tx_data_o    = {24'h0, data_q};
    assign fifo_full_o  = full;
    assign fifo_empty_o = empty;
    assign fifo_level_o = level;
    assign overflow_o   = ovf_q;
endmodule
